guess_entry: RTL and testbench

Front end of the guessing game that produces the guess-submission events the guess counter consumes. It synchronizes and debounces a raw active-low push button and raw guess switches, and emits exactly one single-cycle `submit` pulse per physical press. On each pulse it latches the guess value and registers its comparison against the secret. After a correct guess it locks out further submissions until reset.

---
 rtl/guess_entry.sv | 123 ++++++++++++
 tb/tb_guess_entry.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// Guessing-game front end: synchronizes and debounces the guess button and switches,
// emits one submit pulse per press, and registers the guess against the secret.
module guess_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GUESS_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_n,
    input  logic [GUESS_W-1:0] sw,
    input  logic [GUESS_W-1:0] secret,
    output logic               submit,
    output logic [GUESS_W-1:0] guess,
    output logic               too_high,
    output logic               too_low,
    output logic               correct,
    output logic               busy
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  REL_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        SUBMIT,
        WAIT_REL,
        WON
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               key_p0, key_p1;
    logic [GUESS_W-1:0] sw_p0, sw_p1;
    logic               pressed;

    // Stage p0/p1: two-flop synchronizers for the asynchronous button and switches
    always_ff @(posedge clk) begin
        if (reset) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
        end
    end

    assign pressed = ~key_p1;

    // Debounce FSM: all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            submit   <= 1'b0;
            guess    <= '0;
            too_high <= 1'b0;
            too_low  <= 1'b0;
            correct  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= DEB_PRESS;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (!pressed) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DEB_MAX) begin
                        // Guess and verdict are captured on the same edge submit rises
                        state    <= SUBMIT;
                        cnt      <= '0;
                        submit   <= 1'b1;
                        guess    <= sw_p1;
                        too_high <= (sw_p1 > secret);
                        too_low  <= (sw_p1 < secret);
                        correct  <= (sw_p1 == secret);
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SUBMIT: begin
                    submit <= 1'b0;
                    cnt    <= '0;
                    state  <= correct ? WON : WAIT_REL;
                end
                WAIT_REL: begin
                    if (pressed) begin
                        cnt <= '0;
                    end else if (cnt == REL_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WON: begin
                    state <= WON;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    submit <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry: cycle-exact vector table plus hand sequences for
// release bounce, win lockout and mid-debounce reset.
module tb_guess_entry;

    localparam int D = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_n;
    logic [W-1:0] sw;
    logic [W-1:0] secret;
    logic         submit;
    logic [W-1:0] guess;
    logic         too_high;
    logic         too_low;
    logic         correct;
    logic         busy;

    guess_entry #(.DEBOUNCE_CYCLES(D), .GUESS_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .sw       (sw),
        .secret   (secret),
        .submit   (submit),
        .guess    (guess),
        .too_high (too_high),
        .too_low  (too_low),
        .correct  (correct),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         key;
        logic [W-1:0] swv;
        logic [W-1:0] sec;
        logic         sub;
        logic [W-1:0] g;
        logic         hi;
        logic         lo;
        logic         cor;
        logic         bsy;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic r, input logic k, input logic [W-1:0] s,
                                input logic [W-1:0] sc, input logic sb, input logic [W-1:0] g,
                                input logic hi, input logic lo, input logic cor,
                                input logic bsy, input int n);
        vec_t v;
        v.rst = r; v.key = k; v.swv = s; v.sec = sc;
        v.sub = sb; v.g = g; v.hi = hi; v.lo = lo; v.cor = cor; v.bsy = bsy;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    function automatic logic [12:0] outs();
        return {submit, guess, too_high, too_low, correct, busy};
    endfunction

    function automatic logic [12:0] pack(input logic sb, input logic [W-1:0] g,
                                         input logic hi, input logic lo,
                                         input logic cor, input logic bsy);
        return {sb, g, hi, lo, cor, bsy};
    endfunction

    task automatic step(input logic r, input logic k, input logic [W-1:0] s,
                        input logic [W-1:0] sc);
        reset  = r;
        key_n  = k;
        sw     = s;
        secret = sc;
        @(posedge clk);
        #1;
    endtask

    // Packed output vectors are {submit, guess[7:0], too_high, too_low, correct, busy}
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        key_n  = 1'b1;
        sw     = '0;
        secret = '0;

        // reset with arbitrary inputs, then clean press sw=37 vs secret=50 held 20 edges
        add(1, 0, 8'h55, 8'h11, 0, 0,  0, 0, 0, 0, 2);
        add(0, 1, 37, 50,       0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 37, 50,       0, 0,  0, 0, 0, 0, 2);
        add(0, 0, 37, 50,       0, 0,  0, 0, 0, 1, 4);
        add(0, 0, 37, 50,       1, 37, 0, 1, 0, 1, 1);
        add(0, 0, 37, 50,       0, 37, 0, 1, 0, 1, 13);
        add(0, 1, 37, 50,       0, 37, 0, 1, 0, 1, 5);
        add(0, 1, 37, 50,       0, 37, 0, 1, 0, 0, 3);
        // press bounce: low for three edges only
        add(0, 0, 99, 50,       0, 37, 0, 1, 0, 0, 2);
        add(0, 0, 99, 50,       0, 37, 0, 1, 0, 1, 1);
        add(0, 1, 99, 50,       0, 37, 0, 1, 0, 1, 2);
        add(0, 1, 99, 50,       0, 37, 0, 1, 0, 0, 3);
        // secret change alone does not re-evaluate the flags
        add(0, 1, 99, 30,       0, 37, 0, 1, 0, 0, 2);
        // switch sampling window: sw moves 10 -> 200 right after submit
        add(0, 0, 10, 50,       0, 37, 0, 1, 0, 0, 2);
        add(0, 0, 10, 50,       0, 37, 0, 1, 0, 1, 4);
        add(0, 0, 10, 50,       1, 10, 0, 1, 0, 1, 1);
        add(0, 0, 200, 50,      0, 10, 0, 1, 0, 1, 3);
        add(0, 1, 200, 50,      0, 10, 0, 1, 0, 1, 5);
        add(0, 1, 200, 50,      0, 10, 0, 1, 0, 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].key, vecs[i].swv, vecs[i].sec);
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'(pack(vecs[i].sub, vecs[i].g, vecs[i].hi, vecs[i].lo,
                           vecs[i].cor, vecs[i].bsy)));
        end

        // release bounce: press sw=60 -> too_high, then 2-cycle key toggling in WAIT_REL
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 60, 50);
            check("rb_deb_submit", 32'(submit), 32'd0);
        end
        step(0, 0, 60, 50);
        check("rb_submit", 32'(outs()), 32'(pack(1, 60, 1, 0, 0, 1)));
        for (int i = 0; i < 12; i++) begin
            step(0, ((i % 4) < 2) ? 1'b1 : 1'b0, 60, 50);
            check("rb_toggle", 32'({submit, busy}), 32'b01);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 60, 50);
            check("rb_release_busy", 32'(busy), 32'd1);
        end
        step(0, 1, 60, 50);
        check("rb_release_idle", 32'(outs()), 32'(pack(0, 60, 1, 0, 0, 0)));

        // winning press, then lockout
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 50, 50);
            check("win_deb_submit", 32'(submit), 32'd0);
        end
        step(0, 0, 50, 50);
        check("win_submit", 32'(outs()), 32'(pack(1, 50, 0, 0, 1, 1)));
        for (int i = 0; i < 32; i++) begin
            step(0, (i >= 10 && i < 22) ? 1'b0 : 1'b1, 8'd7, 50);
            check("won_hold", 32'(outs()), 32'(pack(0, 50, 0, 0, 1, 1)));
        end

        // mid-debounce reset with the key held throughout
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("won_reset", 32'(outs()), 32'd0);
        step(0, 1, 77, 50);
        for (int i = 0; i < 4; i++) step(0, 0, 77, 50);
        check("mid_pre_busy", 32'(busy), 32'd1);
        step(1, 0, 123, 50);
        check("mid_reset", 32'(outs()), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 123, 50);
            check("mid_refill", 32'({submit, busy}), 32'({1'b0, (i >= 2) ? 1'b1 : 1'b0}));
        end
        step(0, 0, 123, 50);
        check("mid_submit", 32'(outs()), 32'(pack(1, 123, 1, 0, 0, 1)));
        step(0, 0, 123, 50);
        check("mid_after", 32'(outs()), 32'(pack(0, 123, 1, 0, 0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
